// File: rtl/rs_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : rs_encoder                                                  |
// | Description: Systematic RS(K+NPAR,K) encoder over GF(2^8), poly 0x11B.   |
// |              Builds g(x) from roots alpha^0..alpha^(NPAR-1), then streams.|
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module rs_encoder #(
    parameter int K    = 223,
    parameter int NPAR = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       gen_done
);

    localparam logic [1:0] S_GEN    = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    localparam logic [7:0] c_k_last    = 8'(K - 1);
    localparam logic [7:0] c_npar_last = 8'(NPAR - 1);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [1:0] r_state;
    logic [7:0] r_step;
    logic [7:0] r_cnt;
    logic [7:0] r_r;
    logic [7:0] r_g [0:NPAR];
    logic [7:0] r_p [0:NPAR-1];

    logic [7:0] w_g_next [0:NPAR];
    logic [7:0] w_p_enc  [0:NPAR-1];
    logic [7:0] w_fb;
    logic       w_xfer_data;
    logic       w_xfer_par;

    assign w_fb        = in_data ^ r_p[NPAR-1];
    assign w_xfer_data = (r_state == S_DATA) && in_valid && out_ready;
    assign w_xfer_par  = (r_state == S_PARITY) && out_ready;

    // Multiply the running generator by (x + r) for one root per cycle.
    assign w_g_next[0] = gf_mul(r_r, r_g[0]);
    for (genvar gi = 1; gi <= NPAR; gi++) begin : g_gen_tap
        assign w_g_next[gi] = r_g[gi-1] ^ gf_mul(r_r, r_g[gi]);
    end

    assign w_p_enc[0] = gf_mul(r_g[0], w_fb);
    for (genvar pi = 1; pi < NPAR; pi++) begin : g_enc_tap
        assign w_p_enc[pi] = r_p[pi-1] ^ gf_mul(r_g[pi], w_fb);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_GEN;
            r_step  <= 8'h00;
            r_cnt   <= 8'h00;
            r_r     <= 8'h01;
            for (int i = 0; i <= NPAR; i++) r_g[i] <= (i == 0) ? 8'h01 : 8'h00;
            for (int i = 0; i < NPAR; i++)  r_p[i] <= 8'h00;
        end else begin
            case (r_state)
                S_GEN: begin
                    for (int i = 0; i <= NPAR; i++) r_g[i] <= w_g_next[i];
                    r_r    <= gf_mul(r_r, 8'h03);
                    r_step <= r_step + 8'd1;
                    if (r_step == c_npar_last) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_xfer_data) begin
                        for (int i = 0; i < NPAR; i++) r_p[i] <= w_p_enc[i];
                        if (r_cnt == c_k_last) begin
                            r_state <= S_PARITY;
                            r_cnt   <= 8'h00;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_xfer_par) begin
                        if (r_cnt == c_npar_last) begin
                            r_state <= S_DATA;
                            r_cnt   <= 8'h00;
                            for (int i = 0; i < NPAR; i++) r_p[i] <= 8'h00;
                        end else begin
                            r_cnt  <= r_cnt + 8'd1;
                            r_p[0] <= 8'h00;
                            for (int i = 1; i < NPAR; i++) r_p[i] <= r_p[i-1];
                        end
                    end
                end
                default: r_state <= S_GEN;
            endcase
        end
    end

    // Outputs are forced quiet whenever reset is asserted, even before the edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_DATA: begin
                    in_ready  = out_ready;
                    out_valid = in_valid;
                    out_data  = in_data;
                    out_sop   = (r_cnt == 8'h00) && in_valid;
                end
                S_PARITY: begin
                    out_valid = 1'b1;
                    out_data  = r_p[NPAR-1];
                    out_eop   = (r_cnt == c_npar_last);
                end
                default: ;
            endcase
        end
    end

    assign gen_done = rst_n && (r_state != S_GEN);

endmodule
`default_nettype wire

// File: tb/tb_rs_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_rs_encoder                                               |
// | Description: Directed vectors on RS(5,3) plus streamed RS(255,223) check.|
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rs_encoder;

    localparam int LK   = 223;
    localparam int LN   = 32;
    localparam int NCW  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       s_rst_n = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [7:0] s_in_data = 8'h00;
    logic       s_in_ready, s_out_valid, s_out_sop, s_out_eop, s_gen_done;
    logic [7:0] s_out_data;

    logic       l_rst_n = 1'b0, l_in_valid = 1'b0, l_out_ready = 1'b0;
    logic [7:0] l_in_data = 8'h00;
    logic       l_in_ready, l_out_valid, l_out_sop, l_out_eop, l_gen_done;
    logic [7:0] l_out_data;

    rs_encoder #(.K(3), .NPAR(2)) u_small (
        .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_sop(s_out_sop), .out_eop(s_out_eop),
        .gen_done(s_gen_done)
    );

    rs_encoder #(.K(LK), .NPAR(LN)) u_large (
        .clk(clk), .rst_n(l_rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .in_data(l_in_data), .out_valid(l_out_valid), .out_ready(l_out_ready),
        .out_data(l_out_data), .out_sop(l_out_sop), .out_eop(l_out_eop),
        .gen_done(l_gen_done)
    );

    // exp packs {out_valid, out_data, out_sop, out_eop, in_ready, gen_done}
    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [7:0]  d;
        logic        ordy;
        logic [12:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } sym_t;

    vec_t       vecs[$];
    sym_t       exp_q[$];
    logic [7:0] msg_q[$];

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        logic [7:0] y;
        acc = 8'h00;
        x   = a;
        y   = b;
        while (y != 8'h00) begin
            if (y[0]) acc = acc ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic add(input logic rst, input logic iv, input logic [7:0] d, input logic ordy,
                       input logic ov, input logic [7:0] od, input logic sop, input logic eop,
                       input logic ir, input logic gd);
        vec_t v;
        v.rst_n = rst;
        v.iv    = iv;
        v.d     = d;
        v.ordy  = ordy;
        v.exp   = {ov, od, sop, eop, ir, gd};
        vecs.push_back(v);
    endtask

    logic [7:0] gl [0:LN];
    logic [7:0] cw [0:LK+LN-1];
    logic [7:0] rx [0:LK+LN-1];

    initial begin
        logic [7:0] a;
        logic [7:0] coef;
        logic [7:0] acc;
        int         rx_n;
        int         cyc;
        int         bad_roots;
        logic       seen;
        sym_t       e;

        // Reset, generator build, msg 01 00 00 -> parity 08 09, 5-cycle stall mid-parity
        add(0,1,8'h55,1, 0,8'h00,0,0,0,0);
        add(1,1,8'h55,1, 0,8'h00,0,0,0,0);
        add(1,1,8'h55,1, 0,8'h00,0,0,0,0);
        add(1,1,8'h01,1, 1,8'h01,1,0,1,1);
        add(1,1,8'h00,1, 1,8'h00,0,0,1,1);
        add(1,1,8'h00,1, 1,8'h00,0,0,1,1);
        add(1,1,8'haa,1, 1,8'h08,0,0,0,1);
        for (int i = 0; i < 5; i++) add(1,1,8'haa,0, 1,8'h09,0,1,0,1);
        add(1,1,8'haa,1, 1,8'h09,0,1,0,1);
        // Idle cycle, all-zero codeword, then back-to-back codeword start
        add(1,0,8'h00,1, 0,8'h00,0,0,1,1);
        add(1,1,8'h00,1, 1,8'h00,1,0,1,1);
        add(1,1,8'h00,1, 1,8'h00,0,0,1,1);
        add(1,1,8'h00,1, 1,8'h00,0,0,1,1);
        add(1,0,8'h00,1, 1,8'h00,0,0,0,1);
        add(1,0,8'h00,1, 1,8'h00,0,1,0,1);
        add(1,1,8'h01,1, 1,8'h01,1,0,1,1);
        add(1,1,8'h01,1, 1,8'h01,0,0,1,1);
        // Reset mid-codeword, regeneration, then a clean codeword
        add(0,1,8'h05,1, 0,8'h00,0,0,0,0);
        add(1,1,8'h05,1, 0,8'h00,0,0,0,0);
        add(1,1,8'h05,1, 0,8'h00,0,0,0,0);
        add(1,1,8'h01,1, 1,8'h01,1,0,1,1);
        add(1,1,8'h00,1, 1,8'h00,0,0,1,1);
        add(1,1,8'h00,1, 1,8'h00,0,0,1,1);
        add(1,0,8'h00,1, 1,8'h08,0,0,0,1);
        add(1,0,8'h00,1, 1,8'h09,0,1,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            s_rst_n     = vecs[i].rst_n;
            s_in_valid  = vecs[i].iv;
            s_in_data   = vecs[i].d;
            s_out_ready = vecs[i].ordy;
            #2;
            check($sformatf("vec%0d", i),
                  {19'd0, s_out_valid, s_out_data, s_out_sop, s_out_eop, s_in_ready, s_gen_done},
                  {19'd0, vecs[i].exp});
        end

        // Reference generator by explicit polynomial products (ascending coefficients)
        for (int j = 0; j <= LN; j++) gl[j] = (j == 0) ? 8'h01 : 8'h00;
        a = 8'h01;
        for (int i = 0; i < LN; i++) begin
            for (int j = LN; j >= 1; j--) gl[j] = gl[j-1] ^ mul(a, gl[j]);
            gl[0] = mul(a, gl[0]);
            a = mul(a, 8'h03);
        end

        // Expected stream: parity is the remainder of m(x)*x^NPAR by long division
        for (int c = 0; c < NCW; c++) begin
            for (int i = 0; i < LK + LN; i++) cw[i] = (i < LK) ? 8'($urandom_range(0, 255)) : 8'h00;
            for (int i = 0; i < LK; i++) msg_q.push_back(cw[i]);
            for (int i = 0; i < LK; i++) begin
                coef = cw[i];
                for (int j = 1; j <= LN; j++) cw[i+j] = cw[i+j] ^ mul(coef, gl[LN-j]);
            end
            for (int i = 0; i < LK; i++) cw[i] = msg_q[c*LK + i];
            for (int i = 0; i < LK + LN; i++) begin
                e.d   = cw[i];
                e.sop = (i == 0);
                e.eop = (i == LK + LN - 1);
                exp_q.push_back(e);
            end
        end

        @(negedge clk);
        l_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = l_gen_done;
        end
        check("large_gen_done", {31'd0, seen}, 32'd1);

        rx_n = 0;
        cyc  = 0;
        while (exp_q.size() > 0 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            l_in_valid  = (msg_q.size() > 0) && ($urandom_range(0, 3) != 0);
            l_in_data   = l_in_valid ? msg_q[0] : 8'h00;
            l_out_ready = ($urandom_range(0, 3) != 0);
            #2;
            if (l_in_valid && l_in_ready) void'(msg_q.pop_front());
            if (l_out_valid && l_out_ready) begin
                e = exp_q.pop_front();
                check("stream_sym", {22'd0, l_out_data, l_out_sop, l_out_eop},
                      {22'd0, e.d, e.sop, e.eop});
                rx[rx_n] = l_out_data;
                rx_n++;
                if (rx_n == LK + LN) begin
                    bad_roots = 0;
                    a = 8'h01;
                    for (int r = 0; r < LN; r++) begin
                        acc = 8'h00;
                        for (int j = 0; j < LK + LN; j++) acc = mul(acc, a) ^ rx[j];
                        if (acc != 8'h00) bad_roots++;
                        a = mul(a, 8'h03);
                    end
                    check("codeword_roots", bad_roots, 0);
                    rx_n = 0;
                end
            end
        end
        check("stream_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
